// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command dispatcher: engine opcodes,
// the opcode legality check and the dispatcher state encoding.
package lcd_pkg;

    localparam logic [3:0] OP_WRITE  = 4'd0;
    localparam logic [3:0] OP_SHUP   = 4'd1;
    localparam logic [3:0] OP_SHDN   = 4'd2;
    localparam logic [3:0] OP_SHL    = 4'd3;
    localparam logic [3:0] OP_SHR    = 4'd4;
    localparam logic [3:0] OP_MAX    = 4'd5;
    localparam logic [3:0] OP_MIN    = 4'd6;
    localparam logic [3:0] OP_AVG    = 4'd7;
    localparam logic [3:0] OP_ROTCCW = 4'd8;
    localparam logic [3:0] OP_ROTCW  = 4'd9;
    localparam logic [3:0] OP_MIRX   = 4'd10;
    localparam logic [3:0] OP_MIRY   = 4'd11;
    localparam logic [3:0] OP_LAST   = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_EXEC,
        ST_WDONE,
        ST_FIN
    } disp_state_t;

    // Opcodes above OP_LAST have no engine meaning and are dropped.
    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/lcd_cmd_dispatch_if.sv
// Host-side and engine-side signals of the command dispatcher.
// slave: the dispatcher; master: host plus engine driving it.
interface lcd_cmd_dispatch_if #(
    parameter int CNTW = 8
);
    logic [3:0]      host_cmd;
    logic            host_valid;
    logic            host_ready;
    logic [3:0]      cmd;
    logic            cmd_valid;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] dispatch_cnt;
    logic            finished;
    logic            err;

    modport slave (
        input  host_cmd, host_valid, busy, done,
        output host_ready, cmd, cmd_valid, dispatch_cnt, finished, err
    );

    modport master (
        output host_cmd, host_valid, busy, done,
        input  host_ready, cmd, cmd_valid, dispatch_cnt, finished, err
    );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Opcode FIFO, DEPTH x 4 bits. Pointers carry one extra wrap bit so full
// and empty are told apart without a separate counter. The head word is
// registered: it is reloaded every edge from the slot the read pointer
// will point at, bypassing the write data when that slot is being filled.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [3:0]               head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_next;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
        end
    end

    // Storage and registered head; data only, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
        if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) head <= wr_data;
        else                                             head <= mem[rd_next[AW-1:0]];
    end
endmodule

// File: rtl/lcd_cmd_dispatch.sv
// Command dispatcher in front of the LCD engine: queues host opcodes,
// issues one at a time with a one-cycle cmd_valid strobe, follows the
// engine busy handshake and freezes once a Write has completed.
import lcd_pkg::*;

module lcd_cmd_dispatch #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                clk,
    input  logic                reset,
    lcd_cmd_dispatch_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    disp_state_t     state;
    disp_state_t     state_nx;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic [3:0]      fifo_head;
    logic [AW:0]     fifo_count_unused;
    logic            ready;
    logic            accept;
    logic            issue;
    logic            is_write;
    logic            done_seen;
    logic            err_q;
    logic            cmd_valid_q;
    logic [3:0]      cmd_q;
    logic [CNTW-1:0] cnt_q;

    // No look-ahead on a same-cycle pop: a full FIFO refuses regardless.
    assign ready     = !fifo_full && (state != ST_FIN);
    assign accept    = bus.host_valid && ready;
    assign fifo_push = accept && is_legal(bus.host_cmd);

    assign bus.host_ready   = ready;
    assign bus.cmd          = cmd_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.dispatch_cnt = cnt_q;
    assign bus.finished     = (state == ST_FIN);
    assign bus.err          = err_q;

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (issue),
        .wr_data (bus.host_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count_unused)
    );

    // Dispatcher state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state and issue decision; a zero-cycle command (busy never
    // seen in ACK) completes straight from ACK.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !bus.busy) begin
                    issue    = 1'b1;
                    state_nx = ST_ACK;
                end
            end
            ST_ACK: begin
                if (bus.busy)     state_nx = ST_EXEC;
                else if (is_write) state_nx = ST_WDONE;
                else               state_nx = ST_IDLE;
            end
            ST_EXEC: begin
                if (!bus.busy) state_nx = is_write ? ST_WDONE : ST_IDLE;
            end
            ST_WDONE: begin
                if (bus.done || done_seen) state_nx = ST_FIN;
            end
            ST_FIN:  state_nx = ST_FIN;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Issue register, dispatch counter, Write done latch and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            is_write    <= 1'b0;
            done_seen   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_valid_q <= issue;
            if (issue) begin
                cmd_q     <= fifo_head;
                cnt_q     <= cnt_q + 1'b1;
                is_write  <= (fifo_head == OP_WRITE);
                done_seen <= 1'b0;
            end else if (bus.done && is_write && (state == ST_ACK || state == ST_EXEC)) begin
                done_seen <= 1'b1;
            end
            if (accept && !is_legal(bus.host_cmd)) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_cmd_dispatch.sv
// Bench for lcd_cmd_dispatch: directed host pushes, a small engine model
// that answers each issue with a programmable busy window (and done after
// a Write), and a scoreboard of expected issues checked by a monitor.
`timescale 1ns/1ps
module tb_lcd_cmd_dispatch;
    localparam int DEPTH = 8;
    localparam int CNTW  = 8;

    typedef struct {
        logic [3:0] op;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    lcd_cmd_dispatch_if #(.CNTW(CNTW)) bus();

    lcd_cmd_dispatch #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic [7:0] sb_cnt = 8'd0;

    logic hold_busy = 1'b0;
    int   eng_lat   = 0;
    int   eng_cnt   = 0;
    logic eng_write = 1'b0;
    logic busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Engine model: busy rises in the cycle cmd_valid is high, lasts
    // eng_lat cycles; done pulses as busy falls after a Write.
    always @(posedge clk) begin
        #2;
        bus.done = 1'b0;
        if (reset) begin
            eng_cnt   = 0;
            eng_write = 1'b0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && eng_write) bus.done = 1'b1;
            end
            if (bus.cmd_valid) begin
                eng_write = (bus.cmd == 4'd0);
                if (eng_lat > 0) eng_cnt = eng_lat;
                else if (eng_write) bus.done = 1'b1;
            end
        end
        bus.busy = hold_busy || (eng_cnt > 0);
    end

    // Monitor: every issue must match the head of the scoreboard and must
    // have been decided while the engine was idle.
    always @(negedge clk) begin
        if (bus.cmd_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got cmd %0d cnt %0d, expected no issue at %0t",
                         bus.cmd, bus.dispatch_cnt, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("issue_cmd", 32'(bus.cmd), 32'(e.op));
                chk("issue_cnt", 32'(bus.dispatch_cnt), 32'(e.cnt));
                chk("busy_before_issue", 32'(busy_prev), 32'd0);
            end
        end
        busy_prev = bus.busy;
    end

    task automatic push(input logic [3:0] op, input bit exp_acc);
        @(posedge clk); #1;
        bus.host_cmd   = op;
        bus.host_valid = 1'b1;
        @(negedge clk);
        chk("host_ready_at_push", 32'(bus.host_ready), 32'(exp_acc));
        if (exp_acc && op <= 4'd11) begin
            exp_t e;
            sb_cnt++;
            e.op  = op;
            e.cnt = sb_cnt;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        sb_cnt = 8'd0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d issues still pending after %0d cycles", sb_q.size(), budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.host_cmd   = 4'd0;
        bus.host_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'd0);
        chk("rst_cnt", 32'(bus.dispatch_cnt), 32'd0);
        chk("rst_finished", 32'(bus.finished), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_host_ready", 32'(bus.host_ready), 32'd1);

        // Single Max, engine idle: strobe one edge after the push edge
        begin
            exp_t e;
            @(posedge clk); #1;
            bus.host_cmd   = 4'd5;
            bus.host_valid = 1'b1;
            e.op  = 4'd5;
            e.cnt = 8'd1;
            sb_cnt = 8'd1;
            sb_q.push_back(e);
            @(posedge clk); #1;
            bus.host_valid = 1'b0;
            @(negedge clk);
            chk("lat_not_early", 32'(bus.cmd_valid), 32'd0);
            @(negedge clk);
            chk("lat_cmd_valid", 32'(bus.cmd_valid), 32'd1);
            chk("lat_cmd", 32'(bus.cmd), 32'd5);
            @(negedge clk);
            chk("strobe_one_cycle", 32'(bus.cmd_valid), 32'd0);
            chk("cmd_held", 32'(bus.cmd), 32'd5);
            wait_drain(50);
        end

        // Fill the FIFO while the engine is held busy, then drain in order
        @(posedge clk); #1;
        hold_busy = 1'b1;
        push(4'd1, 1'b1);
        push(4'd2, 1'b1);
        push(4'd3, 1'b1);
        push(4'd4, 1'b1);
        push(4'd6, 1'b1);
        push(4'd7, 1'b1);
        push(4'd8, 1'b1);
        push(4'd10, 1'b1);
        @(negedge clk);
        chk("full_host_ready", 32'(bus.host_ready), 32'd0);
        chk("full_no_issue_cnt", 32'(bus.dispatch_cnt), 32'd1);
        push(4'd11, 1'b0);
        @(posedge clk); #1;
        eng_lat   = 2;
        hold_busy = 1'b0;
        wait_drain(200);
        chk("drain_cnt", 32'(bus.dispatch_cnt), 32'd9);
        chk("drain_host_ready", 32'(bus.host_ready), 32'd1);

        // Illegal opcode is consumed and flagged, then a legal one issues
        push(4'd13, 1'b1);
        @(negedge clk);
        chk("illegal_err", 32'(bus.err), 32'd1);
        chk("illegal_host_ready", 32'(bus.host_ready), 32'd1);
        push(4'd3, 1'b1);
        wait_drain(50);
        chk("after_illegal_cnt", 32'(bus.dispatch_cnt), 32'd10);

        // RotCW with a 4-cycle busy, then Write with done: dispatcher freezes
        @(posedge clk); #1;
        eng_lat = 4;
        push(4'd9, 1'b1);
        push(4'd0, 1'b1);
        begin
            int n;
            n = 0;
            while (!bus.finished && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        chk("fin_finished", 32'(bus.finished), 32'd1);
        chk("fin_host_ready", 32'(bus.host_ready), 32'd0);
        chk("fin_cnt", 32'(bus.dispatch_cnt), 32'd12);
        push(4'd7, 1'b0);
        repeat (10) @(negedge clk);
        chk("fin_err_sticky", 32'(bus.err), 32'd1);

        // Reset in the middle of a long command flushes everything
        do_reset();
        @(posedge clk); #1;
        eng_lat = 20;
        push(4'd14, 1'b1);
        push(4'd1, 1'b1);
        push(4'd2, 1'b1);
        push(4'd3, 1'b1);
        push(4'd4, 1'b1);
        @(negedge clk);
        chk("pre_rst_err", 32'(bus.err), 32'd1);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        sb_cnt  = 8'd0;
        eng_lat = 0;
        @(negedge clk);
        chk("midrst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("midrst_cnt", 32'(bus.dispatch_cnt), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        chk("midrst_finished", 32'(bus.finished), 32'd0);
        chk("midrst_host_ready", 32'(bus.host_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("midrst_fifo_empty_cnt", 32'(bus.dispatch_cnt), 32'd0);

        // 256 zero-latency issues: counter wraps back to 0
        for (int i = 0; i < 256; i++) begin
            push(4'(1 + (i % 11)), 1'b1);
            wait_drain(40);
        end
        chk("wrap_cnt", 32'(bus.dispatch_cnt), 32'd0);
        push(4'd6, 1'b1);
        wait_drain(40);
        chk("wrap_next_cnt", 32'(bus.dispatch_cnt), 32'd1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
